avalon_pio_ext: RTL and testbench

AVALON_PIO_EXT -- requirements
Module: avalon_pio_ext

---
 rtl/avalon_pio_ext.sv | 121 ++++++++++++
 tb/tb_avalon_pio_ext.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_ext.sv
// Avalon-MM parallel I/O port: output/direction/interrupt-mask registers, synchronized inputs,
// sticky edge capture with write-1-to-clear, and a registered level interrupt.
module avalon_pio_ext #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EDGE_TYPE = 0,
    parameter logic [WIDTH-1:0] RESET_OUT = '0,
    localparam int unsigned ADDR_W   = 3,
    localparam int unsigned DATA_W   = 32
) (
    input  logic              in_clk,
    input  logic              in_reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    input  logic [WIDTH-1:0]  pio_in,
    output logic [WIDTH-1:0]  pio_out,
    output logic [WIDTH-1:0]  pio_oe,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] A_DATA    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_DIR     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_IRQMASK = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_EDGECAP = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_OUTSET  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_OUTCLR  = ADDR_W'(5);

    logic [WIDTH-1:0]  sync1, sync2, sync3;
    logic [WIDTH-1:0]  out_reg, dir_reg, mask_reg, edgecap;
    logic [WIDTH-1:0]  wdata, edge_det, cap_clr, edgecap_next, out_next, rd_sel;
    logic [DATA_W-1:0] readdata_q;
    logic              irq_q;
    logic              unused_wdata;

    // Upper write-data bits beyond WIDTH carry no meaning.
    assign unused_wdata = ^avs_writedata;
    assign wdata        = avs_writedata[WIDTH-1:0];

    // Edge detection between the last two synchronizer stages.
    always_comb begin
        edge_det = sync2 ^ sync3;
        if (EDGE_TYPE == 0) begin
            edge_det = sync2 & ~sync3;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~sync2 & sync3;
        end
    end

    // Write decode for the output register and edge-capture clear mask.
    always_comb begin
        out_next = out_reg;
        cap_clr  = '0;
        if (avs_write) begin
            case (avs_address)
                A_DATA:    out_next = wdata;
                A_OUTSET:  out_next = out_reg | wdata;
                A_OUTCLR:  out_next = out_reg & ~wdata;
                A_EDGECAP: cap_clr  = wdata;
                default:   ;
            endcase
        end
        // A new edge outranks a simultaneous clear.
        edgecap_next = (edgecap & ~cap_clr) | edge_det;
    end

    // Read mux; registers are sampled before any same-cycle write lands.
    always_comb begin
        rd_sel = '0;
        case (avs_address)
            A_DATA:    rd_sel = (dir_reg & out_reg) | (~dir_reg & sync2);
            A_DIR:     rd_sel = dir_reg;
            A_IRQMASK: rd_sel = mask_reg;
            A_EDGECAP: rd_sel = edgecap;
            default:   rd_sel = '0;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= pio_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            out_reg    <= RESET_OUT;
            dir_reg    <= '0;
            mask_reg   <= '0;
            edgecap    <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            out_reg <= out_next;
            edgecap <= edgecap_next;
            irq_q   <= |(edgecap & mask_reg);
            if (avs_write && (avs_address == A_DIR)) begin
                dir_reg <= wdata;
            end
            if (avs_write && (avs_address == A_IRQMASK)) begin
                mask_reg <= wdata;
            end
            if (avs_read) begin
                readdata_q <= DATA_W'(rd_sel);
            end
        end
    end

    assign pio_out      = out_reg;
    assign pio_oe       = dir_reg;
    assign irq          = irq_q;
    assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Bench for avalon_pio_ext: rising-edge and any-edge instances share one bus and are checked
// against a history-based register model, a directed vector table and hand-written sequences.
module tb_avalon_pio_ext;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [7:0]  pio_in;

    logic [31:0] rd0, rd2;
    logic [7:0]  out0, out2, oe0, oe2;
    logic        irq0, irq2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    avalon_pio_ext #(.WIDTH(8), .EDGE_TYPE(0), .RESET_OUT(8'h81)) dut0 (
        .in_clk(clk), .in_reset_n(rst_n), .avs_address(address), .avs_read(read),
        .avs_write(write), .avs_writedata(writedata), .avs_readdata(rd0),
        .pio_in(pio_in), .pio_out(out0), .pio_oe(oe0), .irq(irq0));

    avalon_pio_ext #(.WIDTH(8), .EDGE_TYPE(2), .RESET_OUT(8'h81)) dut2 (
        .in_clk(clk), .in_reset_n(rst_n), .avs_address(address), .avs_read(read),
        .avs_write(write), .avs_writedata(writedata), .avs_readdata(rd2),
        .pio_in(pio_in), .pio_out(out2), .pio_oe(oe2), .irq(irq2));

    // Reference model: architectural registers plus the last three sampled input words.
    logic [7:0]  m_out, m_dir, m_mask, m_cap0, m_cap2;
    logic        m_irq0, m_irq2;
    logic [31:0] m_rd0, m_rd2;
    logic [7:0]  hist [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out  = 8'h81;
        m_dir  = 8'h00;
        m_mask = 8'h00;
        m_cap0 = 8'h00;
        m_cap2 = 8'h00;
        m_irq0 = 1'b0;
        m_irq2 = 1'b0;
        m_rd0  = 32'h0;
        m_rd2  = 32'h0;
        for (int i = 0; i < 3; i++) hist[i] = 8'h00;
    endtask

    // Advance the model by one clock edge using the bus inputs present at that edge.
    task automatic model_step();
        logic [7:0] seen, prev, wd, data_view, clr, common;
        seen = hist[1];
        prev = hist[2];
        wd   = writedata[7:0];
        if (read) begin
            data_view = (m_dir & m_out) | (~m_dir & seen);
            common = (address == 3'd0) ? data_view :
                     (address == 3'd1) ? m_dir :
                     (address == 3'd2) ? m_mask : 8'h00;
            m_rd0 = {24'h0, (address == 3'd3) ? m_cap0 : common};
            m_rd2 = {24'h0, (address == 3'd3) ? m_cap2 : common};
        end
        m_irq0 = (m_cap0 & m_mask) != 8'h00;
        m_irq2 = (m_cap2 & m_mask) != 8'h00;
        clr = (write && address == 3'd3) ? wd : 8'h00;
        m_cap0 = (m_cap0 & ~clr) | (seen & ~prev);
        m_cap2 = (m_cap2 & ~clr) | (seen ^ prev);
        if (write) begin
            if (address == 3'd0) m_out = wd;
            if (address == 3'd1) m_dir = wd;
            if (address == 3'd2) m_mask = wd;
            if (address == 3'd4) m_out = m_out | wd;
            if (address == 3'd5) m_out = m_out & ~wd;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = pio_in;
    endtask

    task automatic compare_model();
        chk("pio_out0", 32'(out0), 32'(m_out));
        chk("pio_out2", 32'(out2), 32'(m_out));
        chk("pio_oe0", 32'(oe0), 32'(m_dir));
        chk("pio_oe2", 32'(oe2), 32'(m_dir));
        chk("irq0", 32'(irq0), 32'(m_irq0));
        chk("irq2", 32'(irq2), 32'(m_irq2));
        chk("readdata0", rd0, m_rd0);
        chk("readdata2", rd2, m_rd2);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; write = 1'b1; writedata = d;
        tick();
        write = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wd;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{3'd1, 1'b0, 1'b1, 32'h0000_00FF, 8'h81, 8'hFF, 32'h0};
        vecs[1]  = '{3'd0, 1'b0, 1'b1, 32'h0000_00A5, 8'hA5, 8'hFF, 32'h0};
        vecs[2]  = '{3'd0, 1'b1, 1'b0, 32'h0,         8'hA5, 8'hFF, 32'hA5};
        vecs[3]  = '{3'd6, 1'b1, 1'b0, 32'h0,         8'hA5, 8'hFF, 32'h0};
        vecs[4]  = '{3'd0, 1'b0, 1'b1, 32'h0000_000F, 8'h0F, 8'hFF, 32'h0};
        vecs[5]  = '{3'd4, 1'b0, 1'b1, 32'h0000_0030, 8'h3F, 8'hFF, 32'h0};
        vecs[6]  = '{3'd5, 1'b0, 1'b1, 32'h0000_0003, 8'h3C, 8'hFF, 32'h0};
        vecs[7]  = '{3'd0, 1'b1, 1'b0, 32'h0,         8'h3C, 8'hFF, 32'h3C};
        vecs[8]  = '{3'd4, 1'b1, 1'b0, 32'h0,         8'h3C, 8'hFF, 32'h0};
        vecs[9]  = '{3'd0, 1'b1, 1'b1, 32'hFFFF_FF12, 8'h12, 8'hFF, 32'h3C};
        vecs[10] = '{3'd1, 1'b1, 1'b0, 32'h0,         8'h12, 8'hFF, 32'hFF};
        vecs[11] = '{3'd6, 1'b0, 1'b1, 32'h0000_0055, 8'h12, 8'hFF, 32'hFF};
        vecs[12] = '{3'd1, 1'b0, 1'b1, 32'h0000_000F, 8'h12, 8'h0F, 32'hFF};
        vecs[13] = '{3'd0, 1'b1, 1'b0, 32'h0,         8'h12, 8'h0F, 32'h02};
        vecs[14] = '{3'd5, 1'b1, 1'b0, 32'h0,         8'h12, 8'h0F, 32'h0};
        vecs[15] = '{3'd7, 1'b1, 1'b1, 32'h0000_00FF, 8'h12, 8'h0F, 32'h0};

        rst_n = 1'b0; address = 3'd0; read = 1'b0; write = 1'b0;
        writedata = 32'h0; pio_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pio_out", 32'(out0), 32'h81);
        chk("reset_pio_oe", 32'(oe0), 32'h0);
        chk("reset_irq", 32'(irq0), 32'h0);
        chk("reset_readdata", rd0, 32'h0);
        rst_n = 1'b1;
        model_reset();

        // Directed register-access vectors.
        for (int i = 0; i < 16; i++) begin
            address = vecs[i].addr; read = vecs[i].rd;
            write = vecs[i].wr; writedata = vecs[i].wd;
            tick();
            chk($sformatf("vec%0d_out", i), 32'(out0), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_oe", i), 32'(oe0), 32'(vecs[i].exp_oe));
            chk($sformatf("vec%0d_rd", i), rd0, vecs[i].exp_rd);
        end
        read = 1'b0; write = 1'b0;

        // Rising edge on bit 0 with mask bit 0: capture after 3 edges, irq one later, W1C drops it.
        wr(3'd1, 32'h0); wr(3'd2, 32'h1); wr(3'd3, 32'hFF);
        pio_in = 8'h01;
        tick(); tick();
        chk("edge_irq_early", 32'(irq0), 32'h0);
        tick();
        chk("edge_irq_at_capture", 32'(irq0), 32'h0);
        tick();
        chk("edge_irq_set", 32'(irq0), 32'h1);
        rd_reg(3'd3);
        chk("edgecap_bit0", rd0, 32'h01);
        wr(3'd3, 32'h01);
        tick();
        chk("irq_after_clear", 32'(irq0), 32'h0);

        // Edge on bit 2 coincident with its write-1-clear: the capture survives.
        pio_in = 8'h05;
        tick(); tick(); tick();
        pio_in = 8'h01;
        tick(); tick(); tick();
        pio_in = 8'h05;
        tick(); tick();
        wr(3'd3, 32'h04);
        rd_reg(3'd3);
        chk("set_beats_clear", rd0, 32'h04);
        wr(3'd3, 32'h04);
        rd_reg(3'd3);
        chk("plain_clear", rd0, 32'h00);

        // Masked any-edge pulse on bit 1, then unmask.
        wr(3'd2, 32'h0); wr(3'd3, 32'hFF);
        pio_in = 8'h07;
        repeat (5) tick();
        pio_in = 8'h05;
        repeat (4) tick();
        rd_reg(3'd3);
        chk("anyedge_cap", rd2, 32'h02);
        chk("anyedge_irq_masked", 32'(irq2), 32'h0);
        wr(3'd2, 32'h02);
        chk("anyedge_irq_lag", 32'(irq2), 32'h0);
        tick();
        chk("anyedge_irq_unmasked", 32'(irq2), 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            address = 3'($urandom_range(0, 7));
            read = 1'($urandom_range(0, 1));
            write = ($urandom_range(0, 2) == 0);
            writedata = $urandom;
            if ($urandom_range(0, 3) == 0) pio_in = 8'($urandom);
            tick();
        end
        read = 1'b0; write = 1'b0;

        // Asynchronous reset in the middle of a write.
        wr(3'd1, 32'hF0); wr(3'd2, 32'hFF);
        pio_in = 8'h00;
        repeat (3) tick();
        pio_in = 8'hFF;
        repeat (4) tick();
        chk("pre_reset_irq", 32'(irq0), 32'h1);
        address = 3'd0; write = 1'b1; writedata = 32'h55;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", 32'(out0), 32'h81);
        chk("async_reset_oe", 32'(oe0), 32'h0);
        chk("async_reset_irq0", 32'(irq0), 32'h0);
        chk("async_reset_irq2", 32'(irq2), 32'h0);
        chk("async_reset_rd", rd0, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_discards_write", 32'(out0), 32'h81);
        write = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) rd_reg(3'd3);
        chk("post_reset_cap", rd0, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
